clock_rst_seq: RTL and testbench

Synthesizable, parametrised successor to the bench clock/reset generator. It produces CH independent channels, each with:
- a divided clock-enable tick;
- a reset output held for a programmable number of ticks after start;
- an optional limit on total ticks, after which the channel stops and flags done.

It sits at the top of subsystem test harnesses and FPGA bring-up tops. There it sequences reset release and pacing of downstream blocks from one system clock.

---
 rtl/clock_rst_seq_pkg.sv | 24 ++
 rtl/clock_rst_seq_ch.sv | 201 ++++++++++++++++++++
 rtl/clock_rst_seq.sv | 71 +++++++
 tb/tb_clock_rst_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// clock_rst_seq_pkg
// Shared types and helpers for the clock/reset sequencer:
//   ch_state_e  - per-channel sequencing state
//   CNT_W_DEF   - default width of divider / hold / pulse-count fields
//   ch_lsb()    - LSB index of channel k inside a flattened CH*W bus
// -----------------------------------------------------------------------------
package clock_rst_seq_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } ch_state_e;

    function automatic int ch_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/clock_rst_seq_ch.sv
// -----------------------------------------------------------------------------
// clock_rst_seq_ch
// One sequencer channel: FSM, tick divider, tick counter (shared by the hold
// and pulse-count compares) and, with CLOCK_RST_SEQ_STAGGER_EN defined, a
// start-offset down-counter.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        latch config, clear done, (re)start
//   stop_i         return to IDLE (wins over start_i)
//   div_i          tick period in cycles (0 treated as 1)
//   hold_i         reset hold length in ticks
//   pcount_i       total tick limit, 0 = unlimited
//   ch_en_o        one-cycle tick
//   rst_asrt_o     1 while the channel reset is asserted (polarity applied in top)
//   done_o         sticky pulse-count-reached flag
//   busy_o         channel in HOLD or RUN
//
// Macro: CLOCK_RST_SEQ_STAGGER_EN - enables the WAIT state with OFFSET cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset or stop; no ticks, reset asserted
// WAIT  | counting down the start offset (stagger builds only)
// HOLD  | ticking, reset asserted until hold ticks issued
// RUN   | ticking, reset released (unless DONE reached from HOLD)
// DONE  | pulse count reached; no ticks, reset frozen, done set
// -----------------------------------------------------------------------------
module clock_rst_seq_ch
    import clock_rst_seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int OFFSET = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] hold_i,
    input  logic [CNT_W-1:0] pcount_i,
    output logic             ch_en_o,
    output logic             rst_asrt_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] div_m1_q, div_m1_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] pcount_q, pcount_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             ch_en_q, ch_en_d;
    logic             rst_asrt_q, rst_asrt_d;
    logic             done_q, done_d;

`ifdef CLOCK_RST_SEQ_STAGGER_EN
    localparam int OFF_W = (OFFSET > 1) ? $clog2(OFFSET + 1) : 1;
    logic [OFF_W-1:0] off_cnt_q, off_cnt_d;
`endif

    logic [CNT_W-1:0] div_in_m1;
    logic [CNT_W-1:0] tick_nxt;
    logic             go_active;
    logic [CNT_W-1:0] go_hold;
    logic [CNT_W-1:0] go_div_m1;

    // The divider compares against div-1; a zero period behaves as one.
    assign div_in_m1 = (div_i == '0) ? '0 : (div_i - CNT_W'(1));

    // Tick counter saturates so an unlimited run never wraps into the compares.
    assign tick_nxt = (tick_cnt_q == CNT_MAX) ? tick_cnt_q : (tick_cnt_q + CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        div_m1_d   = div_m1_q;
        hold_d     = hold_q;
        pcount_d   = pcount_q;
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        ch_en_d    = 1'b0;
        rst_asrt_d = rst_asrt_q;
        done_d     = done_q;
        go_active  = 1'b0;
        go_hold    = hold_q;
        go_div_m1  = div_m1_q;
`ifdef CLOCK_RST_SEQ_STAGGER_EN
        off_cnt_d  = off_cnt_q;
`endif

        if (stop_i) begin
            state_d    = ST_IDLE;
            rst_asrt_d = 1'b1;
        end else if (start_i) begin
            div_m1_d   = div_in_m1;
            hold_d     = hold_i;
            pcount_d   = pcount_i;
            done_d     = 1'b0;
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            rst_asrt_d = 1'b1;
            go_hold    = hold_i;
            go_div_m1  = div_in_m1;
`ifdef CLOCK_RST_SEQ_STAGGER_EN
            if (OFFSET != 0) begin
                state_d   = ST_WAIT;
                off_cnt_d = OFF_W'(OFFSET);
            end else begin
                go_active = 1'b1;
            end
`else
            go_active  = 1'b1;
`endif
        end else begin
            unique case (state_q)
`ifdef CLOCK_RST_SEQ_STAGGER_EN
                ST_WAIT: begin
                    if (off_cnt_q == OFF_W'(1)) begin
                        go_active = 1'b1;
                    end else begin
                        off_cnt_d = off_cnt_q - OFF_W'(1);
                    end
                end
`endif
                ST_HOLD, ST_RUN: begin
                    if (div_cnt_q == div_m1_q) begin
                        div_cnt_d  = '0;
                        tick_cnt_d = tick_nxt;
                        // Pulse limit is checked first so pcount <= hold ends in
                        // DONE with the reset still asserted.
                        if ((pcount_q != '0) && (tick_nxt == pcount_q)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if ((state_q == ST_HOLD) && (tick_nxt == hold_q)) begin
                            state_d    = ST_RUN;
                            rst_asrt_d = 1'b0;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + CNT_W'(1);
                    end
                    // ch_en is registered, so it is derived from the next counter value.
                    ch_en_d = (state_d != ST_DONE) && (div_cnt_d == div_m1_q);
                end
                default: begin
                end
            endcase
        end

        // Entry into the ticking phase; hold = 0 skips straight to RUN.
        if (go_active) begin
            state_d    = (go_hold == '0) ? ST_RUN : ST_HOLD;
            rst_asrt_d = (go_hold != '0);
            div_cnt_d  = '0;
            ch_en_d    = (go_div_m1 == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            div_m1_q   <= '0;
            hold_q     <= '0;
            pcount_q   <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            ch_en_q    <= 1'b0;
            rst_asrt_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_m1_q   <= div_m1_d;
            hold_q     <= hold_d;
            pcount_q   <= pcount_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            ch_en_q    <= ch_en_d;
            rst_asrt_q <= rst_asrt_d;
            done_q     <= done_d;
        end
    end

`ifdef CLOCK_RST_SEQ_STAGGER_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_cnt_q <= '0;
        end else begin
            off_cnt_q <= off_cnt_d;
        end
    end
`endif

    assign ch_en_o    = ch_en_q;
    assign rst_asrt_o = rst_asrt_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q == ST_HOLD) || (state_q == ST_RUN);

endmodule

// File: rtl/clock_rst_seq.sv
// -----------------------------------------------------------------------------
// clock_rst_seq
// CH-channel clock-enable / reset sequencer. Each channel produces a divided
// tick, a reset held for a programmable number of ticks, and an optional
// total-tick limit after which it stops and flags done.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     one-cycle pulse: latch config, (re)start all channels
//   stop_i      one-cycle pulse: all channels to IDLE (wins over start_i)
//   div_i       CH*CNT_W tick periods, channel k at [k*CNT_W +: CNT_W]
//   hold_i      CH*CNT_W reset hold lengths in ticks
//   pcount_i    CH*CNT_W total tick limits, 0 = unlimited
//   ch_en_o     CH one-cycle ticks
//   ch_rst_o    CH channel resets, level ACTIVE when asserted
//   done_o      CH sticky done flags
//   busy_o      any channel in HOLD or RUN
//
// Macro: CLOCK_RST_SEQ_STAGGER_EN - channel k waits k*STAGGER cycles before
// HOLD; undefined, all channels start together.
// -----------------------------------------------------------------------------
module clock_rst_seq
    import clock_rst_seq_pkg::*;
#(
    parameter int CH      = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter bit ACTIVE  = 1'b1,
    parameter int STAGGER = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [CH*CNT_W-1:0] div_i,
    input  logic [CH*CNT_W-1:0] hold_i,
    input  logic [CH*CNT_W-1:0] pcount_i,
    output logic [CH-1:0]       ch_en_o,
    output logic [CH-1:0]       ch_rst_o,
    output logic [CH-1:0]       done_o,
    output logic                busy_o
);

    logic [CH-1:0] rst_asrt;
    logic [CH-1:0] busy_vec;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        clock_rst_seq_ch #(
            .CNT_W  (CNT_W),
            .OFFSET (k * STAGGER)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .start_i    (start_i),
            .stop_i     (stop_i),
            .div_i      (div_i[ch_lsb(k, CNT_W) +: CNT_W]),
            .hold_i     (hold_i[ch_lsb(k, CNT_W) +: CNT_W]),
            .pcount_i   (pcount_i[ch_lsb(k, CNT_W) +: CNT_W]),
            .ch_en_o    (ch_en_o[k]),
            .rst_asrt_o (rst_asrt[k]),
            .done_o     (done_o[k]),
            .busy_o     (busy_vec[k])
        );

        // Polarity is a constant select, so the output stays a flop.
        assign ch_rst_o[k] = ACTIVE ? rst_asrt[k] : ~rst_asrt[k];
    end

    assign busy_o = |busy_vec;

endmodule

// File: tb/tb_clock_rst_seq.sv
module tb_clock_rst_seq;

    localparam int CH      = 4;
    localparam int CNT_W   = 16;
    localparam bit ACTIVE  = 1'b1;
    localparam int STAGGER = 8;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                start_i;
    logic                stop_i;
    logic [CH*CNT_W-1:0] div_i;
    logic [CH*CNT_W-1:0] hold_i;
    logic [CH*CNT_W-1:0] pcount_i;
    logic [CH-1:0]       ch_en_o;
    logic [CH-1:0]       ch_rst_o;
    logic [CH-1:0]       done_o;
    logic                busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    clock_rst_seq #(
        .CH      (CH),
        .CNT_W   (CNT_W),
        .ACTIVE  (ACTIVE),
        .STAGGER (STAGGER)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .div_i    (div_i),
        .hold_i   (hold_i),
        .pcount_i (pcount_i),
        .ch_en_o  (ch_en_o),
        .ch_rst_o (ch_rst_o),
        .done_o   (done_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ch(input int k, input int d, input int h, input int p);
        div_i[k*CNT_W +: CNT_W]    = CNT_W'(d);
        hold_i[k*CNT_W +: CNT_W]   = CNT_W'(h);
        pcount_i[k*CNT_W +: CNT_W] = CNT_W'(p);
    endtask

    // Channels not under test: one tick then DONE, busy only in cycle 1.
    task automatic fill_all();
        for (int k = 0; k < CH; k++) set_ch(k, 1, 0, 1);
    endtask

    // Called just after an edge (cycle 0); returns in cycle 1.
    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        div_i    = '0;
        hold_i   = '0;
        pcount_i = '0;
        step();
        step();
        check("rst_en",   32'(ch_en_o),  32'h0);
        check("rst_rst",  32'(ch_rst_o), 32'hF);
        check("rst_done", 32'(done_o),   32'h0);
        check("rst_busy", 32'(busy_o),   32'h0);
        rst_ni = 1'b1;
        step();
        step();

`ifdef CLOCK_RST_SEQ_STAGGER_EN
        // All div=1 hold=1: channel k releases reset at cycle 2 + 8k.
        for (int k = 0; k < CH; k++) set_ch(k, 1, 1, 0);
        pulse_start();
        for (int c = 1; c <= 30; c++) begin
            logic [CH-1:0] exp_rst;
            for (int k = 0; k < CH; k++) exp_rst[k] = (c < 2 + STAGGER * k);
            check($sformatf("stg_rst c%0d", c), 32'(ch_rst_o), 32'(exp_rst));
            if (c != 30) step();
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("stg_stop_en", 32'(ch_en_o), 32'h0);
`else
        // S1: ch0 div=3 hold=2 unlimited; stop at cycle 10.
        fill_all();
        set_ch(0, 3, 2, 0);
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("s1_en c%0d", c),   32'(ch_en_o[0]),  32'((c % 3) == 0));
            check($sformatf("s1_rst c%0d", c),  32'(ch_rst_o[0]), 32'(c < 7));
            check($sformatf("s1_done c%0d", c), 32'(done_o[0]),   32'h0);
            check($sformatf("s1_busy c%0d", c), 32'(busy_o),      32'h1);
            if (c != 10) step();
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("s1_stop_en",   32'(ch_en_o),  32'h0);
        check("s1_stop_rst",  32'(ch_rst_o), 32'hF);
        check("s1_stop_busy", 32'(busy_o),   32'h0);
        check("s1_stop_done", 32'(done_o),   32'hE);
        step();
        step();
        check("s1_idle_en", 32'(ch_en_o), 32'h0);

        // S2: ch1 div=0 hold=0 pcount=5.
        fill_all();
        set_ch(1, 0, 0, 5);
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("s2_en c%0d", c),   32'(ch_en_o[1]),  32'(c <= 5));
            check($sformatf("s2_rst c%0d", c),  32'(ch_rst_o[1]), 32'h0);
            check($sformatf("s2_done c%0d", c), 32'(done_o[1]),   32'(c >= 6));
            check($sformatf("s2_busy c%0d", c), 32'(busy_o),      32'(c <= 5));
            if (c != 8) step();
        end

        // S3: ch2 div=1 hold=4 pcount=2 -> DONE with reset still asserted.
        fill_all();
        set_ch(2, 1, 4, 2);
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("s3_en c%0d", c),   32'(ch_en_o[2]),  32'(c <= 2));
            check($sformatf("s3_rst c%0d", c),  32'(ch_rst_o[2]), 32'h1);
            check($sformatf("s3_done c%0d", c), 32'(done_o[2]),   32'(c >= 3));
            if (c != 6) step();
        end

        // S4: all div=2 hold=1, then start+stop together at cycle 4.
        for (int k = 0; k < CH; k++) set_ch(k, 2, 1, 0);
        pulse_start();
        step();
        step();
        step();
        check("s4_en c4",  32'(ch_en_o),  32'hF);
        check("s4_rst c4", 32'(ch_rst_o), 32'h0);
        for (int k = 0; k < CH; k++) set_ch(k, 1, 0, 0);
        start_i = 1'b1;
        stop_i  = 1'b1;
        step();
        start_i = 1'b0;
        stop_i  = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            check($sformatf("s4_ss_en c%0d", c),   32'(ch_en_o),  32'h0);
            check($sformatf("s4_ss_rst c%0d", c),  32'(ch_rst_o), 32'hF);
            check($sformatf("s4_ss_busy c%0d", c), 32'(busy_o),   32'h0);
            if (c != 8) step();
        end
`endif

        // S5: async reset mid-RUN, then silence until next start.
        for (int k = 0; k < CH; k++) set_ch(k, 1, 0, 0);
        set_ch(CH - 1, 1, 0, 1);
        pulse_start();
`ifndef CLOCK_RST_SEQ_STAGGER_EN
        step();
        step();
        check("s5_run_en",   32'(ch_en_o),  32'h7);
        check("s5_run_done", 32'(done_o),   32'h8);
        check("s5_run_rst",  32'(ch_rst_o), 32'h0);
`endif
        #2;
        rst_ni = 1'b0;
        #1;
        check("s5_arst_en",   32'(ch_en_o),  32'h0);
        check("s5_arst_rst",  32'(ch_rst_o), 32'hF);
        check("s5_arst_done", 32'(done_o),   32'h0);
        check("s5_arst_busy", 32'(busy_o),   32'h0);
        step();
        rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("s5_post_en %0d", c),   32'(ch_en_o),  32'h0);
            check($sformatf("s5_post_rst %0d", c),  32'(ch_rst_o), 32'hF);
            check($sformatf("s5_post_busy %0d", c), 32'(busy_o),   32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
